// File: rtl/dct8_engine.sv
`default_nettype none
// ============================================================================
// Module   : dct8_engine
// Purpose  : Sequential 8-point 1-D DCT core with a four-phase start/done
//            handshake. It snapshots eight signed samples on acceptance and
//            runs one multiply-accumulate per cycle against a coefficient ROM,
//            writing y[k] after every eighth product (64 cycles in total).
// Revision : 1.0 - initial release
// ============================================================================
module dct8_engine #(
  parameter int IN_W  = 12,
  parameter int OUT_W = 16,
  parameter int ACC_W = IN_W + 11
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [8*IN_W-1:0]    din,
  output logic                 busy,
  output logic                 done,
  output logic [8*OUT_W-1:0]   dout
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                    r_state;
  state_t                    w_state_next;
  logic [8*IN_W-1:0]         r_x;
  logic [2:0]                r_k;
  logic [2:0]                r_n;
  logic signed [ACC_W-1:0]   r_acc;
  logic [8*OUT_W-1:0]        r_dout;

  logic                      w_last;
  logic [4:0]                w_odd;
  logic [4:0]                w_kx;
  logic [4:0]                w_ang;
  logic [5:0]                w_fold;
  logic                      w_neg;
  logic signed [7:0]         w_mag;
  logic signed [7:0]         w_coef;
  logic signed [IN_W-1:0]    w_x;
  logic signed [IN_W+7:0]    w_prod;
  logic signed [ACC_W-1:0]   w_acc_next;
  logic signed [ACC_W-1:0]   w_rnd;
  logic [OUT_W-1:0]          w_y;

  assign w_last = (r_n == 3'd7) && (r_k == 3'd7);

  // Angle index (2n+1)*k modulo 32, in units of pi/16; 5-bit product wraps naturally.
  assign w_odd = {1'b0, r_n, 1'b1};
  assign w_kx  = {2'b00, r_k};
  assign w_ang = w_odd * w_kx;

  // Coefficient ROM: fold the angle into the first quadrant and look up 64*cos.
  always_comb begin
    w_fold = {1'b0, w_ang};
    w_neg  = 1'b0;
    if (w_fold > 6'd16) begin
      w_fold = 6'd32 - w_fold;
    end
    if (w_fold > 6'd8) begin
      w_neg  = 1'b1;
      w_fold = 6'd16 - w_fold;
    end
    case (w_fold[3:0])
      4'd0:    w_mag = 8'sd64;
      4'd1:    w_mag = 8'sd63;
      4'd2:    w_mag = 8'sd59;
      4'd3:    w_mag = 8'sd53;
      4'd4:    w_mag = 8'sd45;
      4'd5:    w_mag = 8'sd36;
      4'd6:    w_mag = 8'sd24;
      4'd7:    w_mag = 8'sd12;
      default: w_mag = 8'sd0;
    endcase
    if (r_k == 3'd0) begin
      w_coef = 8'sd45;
    end else if (w_neg) begin
      w_coef = -w_mag;
    end else begin
      w_coef = w_mag;
    end
  end

  // MAC datapath and round-half-up scaling by 2^-7.
  assign w_x        = $signed(r_x[r_n*IN_W +: IN_W]);
  assign w_prod     = w_x * w_coef;
  assign w_acc_next = r_acc + {{(ACC_W-IN_W-8){w_prod[IN_W+7]}}, w_prod};
  assign w_rnd      = w_acc_next + ACC_W'(64);
  assign w_y        = OUT_W'(w_rnd >>> 7);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: four-phase handshake around a fixed 64-cycle computation.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start)  w_state_next = S_CALC;
      S_CALC:  if (w_last) w_state_next = S_DONE;
      S_DONE:  if (!start) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Sample capture, index counters, accumulator and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x    <= '0;
      r_k    <= 3'd0;
      r_n    <= 3'd0;
      r_acc  <= '0;
      r_dout <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_x   <= din;
            r_k   <= 3'd0;
            r_n   <= 3'd0;
            r_acc <= '0;
          end
        end
        S_CALC: begin
          if (r_n == 3'd7) begin
            r_dout[r_k*OUT_W +: OUT_W] <= w_y;
            r_acc <= '0;
            r_n   <= 3'd0;
            r_k   <= r_k + 3'd1;
          end else begin
            r_acc <= w_acc_next;
            r_n   <= r_n + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state == S_CALC);
  assign done = (r_state == S_DONE);
  assign dout = r_dout;

endmodule
`default_nettype wire

// File: tb/tb_dct8_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_dct8_engine
// Purpose  : Directed self-checking bench for dct8_engine.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dct8_engine;
  localparam int IN_W  = 12;
  localparam int OUT_W = 16;

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic [8*IN_W-1:0]   din;
  logic                busy;
  logic                done;
  logic [8*OUT_W-1:0]  dout;

  int checks   = 0;
  int failures = 0;

  dct8_engine #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .din   (din),
    .busy  (busy),
    .done  (done),
    .dout  (dout)
  );

  always #5 clk = ~clk;

  // busy and done must never be high together
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      checks++;
      if (busy === 1'b1 && done === 1'b1) begin
        failures++;
        $display("FAIL busy_done_exclusive busy=%b done=%b required not both 1 at %0t", busy, done, $time);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [8*IN_W-1:0] pack8(input int a0, input int a1, input int a2, input int a3,
                                              input int a4, input int a5, input int a6, input int a7);
    logic [8*IN_W-1:0] v;
    v = {IN_W'(a7), IN_W'(a6), IN_W'(a5), IN_W'(a4), IN_W'(a3), IN_W'(a2), IN_W'(a1), IN_W'(a0)};
    return v;
  endfunction

  // Raise start with given samples; report busy after the acceptance edge and cycles to done.
  task automatic do_run(input logic [8*IN_W-1:0] x, output int lat, output logic b0);
    din   = x;
    start = 1'b1;
    @(posedge clk); #1;
    b0  = busy;
    lat = 0;
    while (done !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; din = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || dout !== '0) begin
      failures++;
      $display("FAIL reset_state busy=%b done=%b dout=%h required 0 0 0", busy, done, dout);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset busy=%b done=%b required 0 0", busy, done);
    end
  endtask

  task automatic test_dc();
    int lat; logic b0;
    logic signed [15:0] exp[8];
    exp = '{16'sd281, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0};
    do_run(pack8(100, 100, 100, 100, 100, 100, 100, 100), lat, b0);
    checks++;
    if (b0 !== 1'b1) begin failures++; $display("FAIL dc_busy_after_accept got=%b required=1", b0); end
    checks++;
    if (lat != 64) begin failures++; $display("FAIL dc_latency got=%0d required=64", lat); end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (dout[k*OUT_W +: OUT_W] !== exp[k]) begin
        failures++;
        $display("FAIL dc_y%0d got=%0d required=%0d", k, $signed(dout[k*OUT_W +: OUT_W]), exp[k]);
      end
    end
    start = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL dc_done_drop got=%b required=0", done); end
  endtask

  task automatic test_impulse_x1();
    int lat; logic b0;
    logic signed [15:0] exp[8];
    exp = '{16'sd45, 16'sd53, 16'sd24, -16'sd12, -16'sd45, -16'sd63, -16'sd59, -16'sd36};
    do_run(pack8(0, 128, 0, 0, 0, 0, 0, 0), lat, b0);
    checks++;
    if (lat != 64) begin failures++; $display("FAIL x1_latency got=%0d required=64", lat); end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (dout[k*OUT_W +: OUT_W] !== exp[k]) begin
        failures++;
        $display("FAIL x1_y%0d got=%0d required=%0d", k, $signed(dout[k*OUT_W +: OUT_W]), exp[k]);
      end
    end
    start = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_handshake();
    int lat; logic b0;
    logic signed [15:0] exp_p[8];
    logic signed [15:0] exp_n[8];
    logic [8*OUT_W-1:0] exp_vec;
    exp_p = '{16'sd45, 16'sd63, 16'sd59, 16'sd53, 16'sd45, 16'sd36, 16'sd24, 16'sd12};
    exp_n = '{-16'sd45, -16'sd63, -16'sd59, -16'sd53, -16'sd45, -16'sd36, -16'sd24, -16'sd12};
    for (int k = 0; k < 8; k++) exp_vec[k*OUT_W +: OUT_W] = exp_p[k];
    do_run(pack8(128, 0, 0, 0, 0, 0, 0, 0), lat, b0);
    checks++;
    if (lat != 64) begin failures++; $display("FAIL pos_latency got=%0d required=64", lat); end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (dout[k*OUT_W +: OUT_W] !== exp_p[k]) begin
        failures++;
        $display("FAIL pos_y%0d got=%0d required=%0d", k, $signed(dout[k*OUT_W +: OUT_W]), exp_p[k]);
      end
    end
    // start held high in DONE: no restart, outputs frozen
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || dout !== exp_vec) begin
        failures++;
        $display("FAIL hold_done cyc=%0d done=%b busy=%b dout=%h required 1 0 %h", i, done, busy, dout, exp_vec);
      end
    end
    start = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL release_done done=%b busy=%b required 0 0", done, busy);
    end
    // earliest re-acceptance: next edge, negative impulse
    do_run(pack8(-128, 0, 0, 0, 0, 0, 0, 0), lat, b0);
    checks++;
    if (b0 !== 1'b1) begin failures++; $display("FAIL rerun_accept busy=%b required=1", b0); end
    checks++;
    if (lat != 64) begin failures++; $display("FAIL neg_latency got=%0d required=64", lat); end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (dout[k*OUT_W +: OUT_W] !== exp_n[k]) begin
        failures++;
        $display("FAIL neg_y%0d got=%0d required=%0d", k, $signed(dout[k*OUT_W +: OUT_W]), exp_n[k]);
      end
    end
    start = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_busy_isolation();
    int lat;
    logic signed [15:0] exp[8];
    exp = '{16'sd281, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0};
    din = pack8(100, 100, 100, 100, 100, 100, 100, 100);
    start = 1'b1;
    @(posedge clk); #1;
    repeat (10) @(posedge clk);
    #1;
    din = pack8(-128, 7, 300, -5, 0, 99, -1000, 42);
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1;
    lat = 12;
    while (done !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat != 64) begin failures++; $display("FAIL iso_latency got=%0d required=64", lat); end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (dout[k*OUT_W +: OUT_W] !== exp[k]) begin
        failures++;
        $display("FAIL iso_y%0d got=%0d required=%0d", k, $signed(dout[k*OUT_W +: OUT_W]), exp[k]);
      end
    end
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        failures++;
        $display("FAIL iso_no_extra_run cyc=%0d busy=%b done=%b required 0 0", i, busy, done);
      end
    end
  endtask

  task automatic test_reset_mid();
    int lat; logic b0;
    logic signed [15:0] exp[8];
    exp = '{16'sd45, 16'sd63, 16'sd59, 16'sd53, 16'sd45, 16'sd36, 16'sd24, 16'sd12};
    din = pack8(100, 100, 100, 100, 100, 100, 100, 100);
    start = 1'b1;
    @(posedge clk); #1;
    repeat (29) @(posedge clk);
    #1;
    rst = 1'b1;
    din = pack8(128, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || dout !== '0) begin
      failures++;
      $display("FAIL mid_reset busy=%b done=%b dout=%h required 0 0 0", busy, done, dout);
    end
    rst = 1'b0;
    do_run(pack8(128, 0, 0, 0, 0, 0, 0, 0), lat, b0);
    checks++;
    if (b0 !== 1'b1) begin failures++; $display("FAIL post_reset_accept busy=%b required=1", b0); end
    checks++;
    if (lat != 64) begin failures++; $display("FAIL post_reset_latency got=%0d required=64", lat); end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (dout[k*OUT_W +: OUT_W] !== exp[k]) begin
        failures++;
        $display("FAIL post_reset_y%0d got=%0d required=%0d", k, $signed(dout[k*OUT_W +: OUT_W]), exp[k]);
      end
    end
    start = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_dc();
    test_impulse_x1();
    test_handshake();
    test_busy_isolation();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
